// File: rtl/dp_sched_pkg.sv
// dp_sched_pkg: shared types and constants for the dot-product MAC scheduler.
//   state_e      : scheduler FSM states
//   ELEM_CYCLES  : cycles spent per issued element with the default core delays
//   elem_cycles(): same figure for arbitrary multiplier/adder delays
package dp_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        MUL_W,
        ADD,
        ADD_W,
        DONE
    } state_e;

    localparam int FPM_DELAY_DEF = 6;
    localparam int FPA_DELAY_DEF = 2;
    localparam int ELEM_CYCLES   = 2 + FPM_DELAY_DEF + FPA_DELAY_DEF;

    function automatic int elem_cycles(input int fpm, input int fpa);
        return 2 + fpm + fpa;
    endfunction

endpackage

// File: rtl/dp_mac_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i  : request vector, one bit per requester
//   last_i : id of the previous grant; the search starts just after it
//   vld_o  : at least one request is set
//   id_o   : winning requester id
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic            vld_o,
    output logic [IDW-1:0]  id_o
);

    int k;

    // Walk offsets from farthest to nearest so the nearest set bit after
    // last_i is the one left standing. Offset NREQ wraps back to last_i, so
    // a lone requester can still be re-granted.
    always_comb begin
        vld_o = 1'b0;
        id_o  = '0;
        k     = 0;
        for (int i = NREQ; i >= 1; i--) begin
            k = (int'(last_i) + i) % NREQ;
            if (req_i[k]) begin
                vld_o = 1'b1;
                id_o  = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/dp_mac_scheduler.sv
// dp_mac_scheduler: shares one multiplier/adder pair among NREQ requesters,
// computing each granted requester's PIXEL_N-element dot product serially.
// Optional feature macro: DP_SCHED_SKIPZERO_EN (skip elements whose pixel is 0).
//   clk, GlobalReset        : clock, synchronous active-low reset
//   req_i                   : level requests
//   pixels_i / weights_i    : flattened operands, requester-major, element-minor
//   mul_weight_o/mul_pixel_o: multiplier operands (registered)
//   mul_result_i            : multiplier result
//   add_a_o / add_b_o       : adder operands: product / running sum (registered)
//   add_result_i            : adder result
//   busy_o, gnt_id_o        : job in progress and its requester
//   done_o, done_id_o       : one-cycle result pulse and its requester
//   value_o                 : dot product, held until the next done_o
module dp_mac_scheduler
    import dp_sched_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int PIXEL_N     = 10,
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int VAL_SIZE    = 26,
    parameter int FPM_DELAY   = FPM_DELAY_DEF,
    parameter int FPA_DELAY   = FPA_DELAY_DEF
) (
    input  logic                                  clk,
    input  logic                                  GlobalReset,
    input  logic [NREQ-1:0]                       req_i,
    input  logic [NREQ*PIXEL_N*PIXEL_SIZE-1:0]    pixels_i,
    input  logic [NREQ*PIXEL_N*WEIGHT_SIZE-1:0]   weights_i,
    output logic [WEIGHT_SIZE-1:0]                mul_weight_o,
    output logic [PIXEL_SIZE-1:0]                 mul_pixel_o,
    input  logic [VAL_SIZE-1:0]                   mul_result_i,
    output logic [VAL_SIZE-1:0]                   add_a_o,
    output logic [VAL_SIZE-1:0]                   add_b_o,
    input  logic [VAL_SIZE-1:0]                   add_result_i,
    output logic                                  busy_o,
    output logic [$clog2(NREQ)-1:0]               gnt_id_o,
    output logic                                  done_o,
    output logic [$clog2(NREQ)-1:0]               done_id_o,
    output logic [VAL_SIZE-1:0]                   value_o
);

    localparam int IDW  = $clog2(NREQ);
    localparam int IXW  = (PIXEL_N > 1) ? $clog2(PIXEL_N) : 1;
    localparam int DMAX = (FPM_DELAY > FPA_DELAY) ? FPM_DELAY : FPA_DELAY;
    localparam int CW   = $clog2(DMAX + 1);

    state_e                 state_q, state_d;
    logic [IXW-1:0]         idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [VAL_SIZE-1:0]    sum_q, sum_d;
    logic [IDW-1:0]         last_q, last_d;
    logic [IDW-1:0]         gnt_q, gnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [IDW-1:0]         done_id_q, done_id_d;
    logic [VAL_SIZE-1:0]    value_q, value_d;
    logic [WEIGHT_SIZE-1:0] mw_q, mw_d;
    logic [PIXEL_SIZE-1:0]  mp_q, mp_d;
    logic [VAL_SIZE-1:0]    aa_q, aa_d;
    logic [VAL_SIZE-1:0]    ab_q, ab_d;

    logic                   arb_vld;
    logic [IDW-1:0]         arb_id;
    logic [PIXEL_SIZE-1:0]  cur_pix;
    logic [WEIGHT_SIZE-1:0] cur_wt;
    logic                   last_elem;
    logic                   skip_zero;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i  (req_i),
        .last_i (last_q),
        .vld_o  (arb_vld),
        .id_o   (arb_id)
    );

    // Operands are read live from the granted slice; the requester holds
    // them stable for the whole job.
    assign cur_pix   = pixels_i[(int'(gnt_q)*PIXEL_N + int'(idx_q))*PIXEL_SIZE +: PIXEL_SIZE];
    assign cur_wt    = weights_i[(int'(gnt_q)*PIXEL_N + int'(idx_q))*WEIGHT_SIZE +: WEIGHT_SIZE];
    assign last_elem = (idx_q == IXW'(PIXEL_N-1));

`ifdef DP_SCHED_SKIPZERO_EN
    assign skip_zero = (cur_pix == '0);
`else
    assign skip_zero = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        value_d   = value_q;
        mw_d      = mw_q;
        mp_d      = mp_q;
        aa_d      = aa_q;
        ab_d      = ab_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    gnt_d   = arb_id;
                    last_d  = arb_id;
                    busy_d  = 1'b1;
                    sum_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (skip_zero) begin
                    // Zero pixel contributes nothing: no core issue at all.
                    if (last_elem) state_d = DONE;
                    else           idx_d   = idx_q + 1'b1;
                end else begin
                    mw_d    = cur_wt;
                    mp_d    = cur_pix;
                    state_d = MUL_W;
                end
            end
            MUL_W: begin
                if (cnt_q == CW'(FPM_DELAY-1)) begin
                    cnt_d   = '0;
                    state_d = ADD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ADD: begin
                aa_d    = mul_result_i;
                ab_d    = sum_q;
                state_d = ADD_W;
            end
            ADD_W: begin
                if (cnt_q == CW'(FPA_DELAY-1)) begin
                    cnt_d = '0;
                    sum_d = add_result_i;
                    if (last_elem) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = MUL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Result outputs are registered, so done_o is seen in the
                // IDLE cycle that follows; busy_o drops on the same edge.
                done_d    = 1'b1;
                value_d   = sum_q;
                done_id_d = gnt_q;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            last_q    <= IDW'(NREQ-1);
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            value_q   <= '0;
            mw_q      <= '0;
            mp_q      <= '0;
            aa_q      <= '0;
            ab_q      <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            value_q   <= value_d;
            mw_q      <= mw_d;
            mp_q      <= mp_d;
            aa_q      <= aa_d;
            ab_q      <= ab_d;
        end
    end

    assign mul_weight_o = mw_q;
    assign mul_pixel_o  = mp_q;
    assign add_a_o      = aa_q;
    assign add_b_o      = ab_q;
    assign busy_o       = busy_q;
    assign gnt_id_o     = gnt_q;
    assign done_o       = done_q;
    assign done_id_o    = done_id_q;
    assign value_o      = value_q;

endmodule

// File: tb/tb_dp_mac_scheduler.sv
// Bench for dp_mac_scheduler: ideal multiply (6) / add (2) models, a
// table of multi-requester jobs, plus hand sequences for reset abort,
// drop/re-request and zero-pixel skipping.
module tb_dp_mac_scheduler;

    localparam int NREQ = 4, PN = 10, PS = 10, WS = 19, VS = 26;
`ifdef DP_SCHED_SKIPZERO_EN
    localparam int LAT_SKIP = 20;
`else
    localparam int LAT_SKIP = 101;
`endif

    logic                 clk = 1'b0;
    logic                 GlobalReset;
    logic [NREQ-1:0]      req;
    logic [NREQ*PN*PS-1:0] pixels_flat;
    logic [NREQ*PN*WS-1:0] weights_flat;
    logic [WS-1:0]        mul_weight_o;
    logic [PS-1:0]        mul_pixel_o;
    logic [VS-1:0]        mul_result;
    logic [VS-1:0]        add_a_o, add_b_o, add_result;
    logic                 busy_o, done_o;
    logic [1:0]           gnt_id_o, done_id_o;
    logic [VS-1:0]        value_o;

    logic [PS-1:0] pix [NREQ][PN];
    logic [WS-1:0] wt  [NREQ][PN];

    always #5 clk = ~clk;

    dp_mac_scheduler dut (
        .clk          (clk),
        .GlobalReset  (GlobalReset),
        .req_i        (req),
        .pixels_i     (pixels_flat),
        .weights_i    (weights_flat),
        .mul_weight_o (mul_weight_o),
        .mul_pixel_o  (mul_pixel_o),
        .mul_result_i (mul_result),
        .add_a_o      (add_a_o),
        .add_b_o      (add_b_o),
        .add_result_i (add_result),
        .busy_o       (busy_o),
        .gnt_id_o     (gnt_id_o),
        .done_o       (done_o),
        .done_id_o    (done_id_o),
        .value_o      (value_o)
    );

    always_comb begin
        pixels_flat  = '0;
        weights_flat = '0;
        for (int k = 0; k < NREQ; k++)
            for (int e = 0; e < PN; e++) begin
                pixels_flat[(k*PN+e)*PS +: PS]  = pix[k][e];
                weights_flat[(k*PN+e)*WS +: WS] = wt[k][e];
            end
    end

    // Ideal cores: results usable 6 / 2 edges after the operands are registered.
    logic [VS-1:0] mpipe [5];
    logic [VS-1:0] areg;
    always @(posedge clk) begin
        mpipe[0] <= VS'(longint'(mul_weight_o) * longint'(mul_pixel_o));
        for (int i = 1; i < 5; i++) mpipe[i] <= mpipe[i-1];
        areg <= add_a_o + add_b_o;
    end
    assign mul_result = mpipe[4];
    assign add_result = areg;

    typedef struct {
        int            id;
        logic [VS-1:0] val;
        int            lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic          rst;
        logic [3:0]    req;
        int            pat;
        int            n;
        logic [7:0]    order;
        longint        cval;
    } vec_t;
    vec_t vt[5];

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            gstart[NREQ];
    logic          busy_prev = 1'b0;
    logic [VS-1:0] last_val = '0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One cycle: scoreboard pop on done_o, grant timestamps, requester drop.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (busy_o && !busy_prev) gstart[gnt_id_o] = cyc;
        busy_prev = busy_o;
        if (done_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got id %0d value %0d expected none", done_id_o, value_o);
            end else begin
                e = sb.pop_front();
                chk("done_id", longint'(done_id_o), longint'(e.id));
                chk("value", longint'(value_o), longint'(e.val));
                if (e.lat > 0) chk("latency", longint'(cyc - gstart[e.id]), longint'(e.lat));
            end
            last_val = value_o;
            req[done_id_o] = 1'b0;
        end
    endtask

    task automatic wait_quiet(input int maxc);
        int n = 0;
        while ((sb.size() != 0 || busy_o) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", longint'(busy_o), 0);
        chk("rst_done", longint'(done_o), 0);
        chk("rst_gnt_id", longint'(gnt_id_o), 0);
        chk("rst_done_id", longint'(done_id_o), 0);
        chk("rst_value", longint'(value_o), 0);
        chk("rst_mul_w", longint'(mul_weight_o), 0);
        chk("rst_mul_p", longint'(mul_pixel_o), 0);
        chk("rst_add_a", longint'(add_a_o), 0);
        chk("rst_add_b", longint'(add_b_o), 0);
    endtask

    task automatic do_reset();
        req = '0;
        sb.delete();
        GlobalReset = 1'b0;
        tick();
        tick();
        chk_reset_outputs();
        GlobalReset = 1'b1;
    endtask

    task automatic set_data(input int pat);
        for (int k = 0; k < NREQ; k++)
            for (int e = 0; e < PN; e++)
                case (pat)
                    0: begin pix[k][e] = PS'(e + 1); wt[k][e] = WS'(1); end
                    1: begin
                        pix[k][e] = PS'((k*37 + e*101) % 1023 + 1);
                        wt[k][e]  = WS'((k*5003 + e*977) % (1 << 19));
                    end
                    2: begin pix[k][e] = PS'(1023); wt[k][e] = WS'((1 << 18) - 1); end
                    default: begin
                        pix[k][e] = PS'($urandom_range(1, 1023));
                        wt[k][e]  = WS'($urandom_range(0, (1 << 19) - 1));
                    end
                endcase
    endtask

    function automatic logic [VS-1:0] dot(input int k);
        longint s = 0;
        for (int e = 0; e < PN; e++) s += longint'(pix[k][e]) * longint'(wt[k][e]);
        return s[VS-1:0];
    endfunction

    task automatic push(input int id, input logic [VS-1:0] v, input int lat);
        exp_t e;
        e.id = id; e.val = v; e.lat = lat;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e0;
        int   c0;
        int   n;
        logic [VS-1:0] first_val;

        //           rst   req      pat n  order (id n at [2n+1:2n])  const
        vt[0] = '{1'b1, 4'b0001, 0, 1, 8'b00_00_00_00, 55};
        vt[1] = '{1'b1, 4'b1111, 1, 4, 8'b11_10_01_00, -1};
        vt[2] = '{1'b0, 4'b1010, 2, 2, 8'b00_00_11_01, -1};
        vt[3] = '{1'b1, 4'b0100, 3, 1, 8'b00_00_00_10, -1};
        vt[4] = '{1'b1, 4'b1100, 1, 2, 8'b00_00_11_10, -1};

        GlobalReset = 1'b0;
        req = '0;
        set_data(0);
        for (int k = 0; k < NREQ; k++) gstart[k] = 0;

        for (int v = 0; v < 5; v++) begin
            if (vt[v].rst) do_reset();
            set_data(vt[v].pat);
            for (int i = 0; i < vt[v].n; i++) begin
                int id;
                id = int'(vt[v].order[2*i +: 2]);
                push(id, dot(id), 101);
            end
            req = vt[v].req;
            wait_quiet(600);
            if (vt[v].cval >= 0) chk("const_value", longint'(last_val), vt[v].cval);
        end

        // Reset in the middle of element 4's multiply wait.
        set_data(1);
        req = 4'b0001;
        n = 0;
        while (!busy_o && n < 20) begin tick(); n++; end
        chk("abort_granted", longint'(busy_o), 1);
        c0 = cyc;
        while (cyc < c0 + 43) tick();
        GlobalReset = 1'b0;
        tick();
        chk_reset_outputs();
        tick();
        chk("abort_no_done", longint'(done_o), 0);
        GlobalReset = 1'b1;
        push(0, dot(0), 101);
        wait_quiet(300);

        // Drop after done, re-request 5 cycles later: same result.
        set_data(3);
        push(2, dot(2), 101);
        req = 4'b0100;
        wait_quiet(300);
        first_val = last_val;
        for (int i = 0; i < 5; i++) tick();
        chk("no_regrant", longint'(busy_o), 0);
        push(2, dot(2), 101);
        req = 4'b0100;
        wait_quiet(300);
        chk("repeat_value", longint'(last_val), longint'(first_val));

        // Sparse pixels: only element 2 is nonzero.
        for (int e = 0; e < PN; e++) begin
            pix[0][e] = '0;
            wt[0][e]  = WS'(2);
        end
        pix[0][2] = PS'(3);
        push(0, VS'(6), LAT_SKIP);
        req = 4'b0001;
        wait_quiet(300);

        tick();
        tick();
        chk("final_idle", longint'(busy_o), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
